// File: rtl/frame_buffer_if.sv
// Capture-write and SPI-read signal bundle for the ping-pong frame buffer.
// The master side is the capture/SPI producer. The slave side is the buffer.
interface frame_buffer_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [7:0]            wr_data;
    logic                  wr_last;
    logic                  cs;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic [7:0]            rd_data;
    logic                  frame_ready;
    logic [7:0]            frame_count;

    modport master (
        output wr_valid, wr_data, wr_last, cs, rd_address,
        input  wr_ready, rd_data, frame_ready, frame_count
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, cs, rd_address,
        output wr_ready, rd_data, frame_ready, frame_count
    );
endinterface

// File: rtl/frame_buffer.sv
// Ping-pong byte store: capture fills the back bank while SPI reads the front bank.
// Banks swap only while chip select is idle, so a reader never sees a torn frame.
module frame_buffer #(
    parameter int DEPTH      = 1536,
    parameter int ADDR_WIDTH = 14
) (
    input  logic           clk,
    input  logic           reset,
    frame_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] wr_ptr;
    logic             front;
    logic             cs_meta;
    logic             cs_s;
    logic             cs_s_q;
    logic             frame_ready_q;
    logic [7:0]       frame_count_q;
    logic [7:0]       rd_data_q;
    logic [7:0]       mem [2][DEPTH];

    logic             wr_fire;
    logic             frame_done;
    logic             swap;
    logic             read_start;
    logic             rd_in_range;
    logic             wr_ready_c;

    // HOLD is the swap-pending condition; a read start (cs_s low) inherently blocks the swap.
    always_comb begin
        wr_ready_c  = 1'b0;
        state_next  = state;
        wr_fire     = 1'b0;
        frame_done  = 1'b0;
        swap        = 1'b0;
        read_start  = cs_s_q && !cs_s;
        rd_in_range = {1'b0, bus.rd_address} < DEPTH_EXT;
        case (state)
            FILL: begin
                wr_ready_c = 1'b1;
                wr_fire    = bus.wr_valid;
                frame_done = bus.wr_valid && (bus.wr_last || (wr_ptr == LAST_PTR));
                if (frame_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                swap = cs_s;
                if (cs_s) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // cs is driven from the SPI clock domain; idle-high reset keeps a reset from looking like a read start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_s_q  <= 1'b1;
        end else begin
            cs_meta <= bus.cs;
            cs_s    <= cs_meta;
            cs_s_q  <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (frame_done) begin
            wr_ptr <= '0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front         <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_count_q <= '0;
        end else if (swap) begin
            front         <= ~front;
            frame_ready_q <= 1'b1;
            frame_count_q <= frame_count_q + 8'd1;
        end else if (read_start) begin
            frame_ready_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[~front][wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_in_range) begin
            rd_data_q <= mem[front][bus.rd_address[PTR_W-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.wr_ready    = wr_ready_c;
    assign bus.rd_data     = rd_data_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_frame_buffer.sv
// Randomized bench for frame_buffer, checked against a bank-level reference model.
// The model keeps both banks as arrays and applies the publish/read rules directly.
module tb_frame_buffer;
    localparam int DEPTH = 1536;
    localparam int AW    = 14;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    frame_buffer_if #(.ADDR_WIDTH(AW)) bus ();

    frame_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_bank  [2][DEPTH];
    bit         m_known [2][DEPTH];
    int         m_ptr;
    bit         m_pending;
    bit         m_front;
    bit         m_ready;
    logic [7:0] m_count;
    bit         m_cs1, m_cs2, m_cs3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_pending = 0;
        m_front   = 0;
        m_ready   = 0;
        m_count   = 8'd0;
        m_cs1     = 1;
        m_cs2     = 1;
        m_cs3     = 1;
    endtask

    // One clock: drive inputs, advance DUT and model, compare all outputs.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                         input logic c, input logic [AW-1:0] a, output logic acc);
        bit         cs_idle;
        bit         rd_start;
        bit         rd_ok;
        logic [7:0] rd_exp;
        bus.wr_valid   = v;
        bus.wr_data    = d;
        bus.wr_last    = l;
        bus.cs         = c;
        bus.rd_address = a;
        cs_idle  = m_cs2;
        rd_start = m_cs3 && !m_cs2;
        rd_ok    = 1;
        rd_exp   = 8'h00;
        if (int'(a) < DEPTH) begin
            rd_ok  = m_known[m_front][int'(a)];
            rd_exp = m_bank[m_front][int'(a)];
        end
        acc = v && !m_pending;
        @(posedge clk);
        #1;
        if (m_pending && cs_idle) begin
            m_front   = !m_front;
            m_pending = 0;
            m_ready   = 1;
            m_count   = m_count + 8'd1;
        end else if (rd_start) begin
            m_ready = 0;
        end
        if (acc) begin
            m_bank[!m_front][m_ptr]  = d;
            m_known[!m_front][m_ptr] = 1;
            if (l || m_ptr == DEPTH - 1) begin
                m_ptr     = 0;
                m_pending = 1;
            end else begin
                m_ptr++;
            end
        end
        m_cs3 = m_cs2;
        m_cs2 = m_cs1;
        m_cs1 = c;
        check("wr_ready", {31'd0, bus.wr_ready}, {31'd0, !m_pending});
        check("frame_ready", {31'd0, bus.frame_ready}, {31'd0, m_ready});
        check("frame_count", {24'd0, bus.frame_count}, {24'd0, m_count});
        if (rd_ok) check("rd_data", {24'd0, bus.rd_data}, {24'd0, rd_exp});
    endtask

    task automatic idle(input logic c, input logic [AW-1:0] a, input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, c, a, acc);
    endtask

    // Offer one byte until accepted, bounded.
    task automatic send_byte(input logic [7:0] d, input logic l, input logic c);
        logic acc;
        int   tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 200) begin
            cycle(1'b1, d, l, c, 14'd0, acc);
            tries++;
        end
        if (!acc) check("stall_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.cs       = 1'b1;
        reset        = 1'b1;
        #1;
        check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
        check("rst_frame_ready", {31'd0, bus.frame_ready}, 32'd0);
        check("rst_frame_count", {24'd0, bus.frame_count}, 32'd0);
        check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = 8'h00;
        bus.wr_last    = 1'b0;
        bus.cs         = 1'b1;
        bus.rd_address = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) m_known[b][i] = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1: full frame 0..1535, cs idle
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), i == DEPTH - 1, 1'b1);
        check("t1_hold", {31'd0, bus.wr_ready}, 32'd0);
        idle(1'b1, 14'd0, 1);
        check("t1_ready", {31'd0, bus.frame_ready}, 32'd1);
        check("t1_count", {24'd0, bus.frame_count}, 32'd1);
        idle(1'b1, 14'd5, 1);
        check("t1_rd5", {24'd0, bus.rd_data}, 32'd5);

        // 2: frame completes during a transfer
        idle(1'b0, 14'd5, 3);
        check("t2_ready_clr", {31'd0, bus.frame_ready}, 32'd0);
        for (int i = 0; i < DEPTH; i++) send_byte(8'hA5, i == DEPTH - 1, 1'b0);
        idle(1'b0, 14'd5, 4);
        check("t2_blocked", {31'd0, bus.wr_ready}, 32'd0);
        check("t2_count", {24'd0, bus.frame_count}, 32'd1);
        check("t2_old_data", {24'd0, bus.rd_data}, 32'd5);
        idle(1'b1, 14'd5, 3);
        check("t2_swap", {24'd0, bus.frame_count}, 32'd2);
        idle(1'b1, 14'd5, 1);
        check("t2_new_data", {24'd0, bus.rd_data}, 32'hA5);

        // 3: stalled byte accepted after the swap
        idle(1'b0, 14'd0, 3);
        for (int i = 0; i < 4; i++) send_byte(8'h3C, i == 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h11, 1'b0, 1'b0, 14'd0, acc);
            check("t3_stall", {31'd0, acc}, 32'd0);
        end
        send_byte(8'h11, 1'b0, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        idle(1'b1, 14'd0, 2);
        check("t3_byte0", {24'd0, bus.rd_data}, 32'h11);

        // 4: short frame and out-of-range reads
        for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i), i == 9, 1'b1);
        idle(1'b1, 14'd0, 1);
        for (int i = 0; i < 10; i++) begin
            idle(1'b1, 14'(i), 1);
            check("t4_short", {24'd0, bus.rd_data}, 32'h80 + i);
        end
        idle(1'b1, 14'd1536, 1);
        check("t4_oor1536", {24'd0, bus.rd_data}, 32'd0);
        idle(1'b1, 14'd16383, 1);
        check("t4_oor16383", {24'd0, bus.rd_data}, 32'd0);

        // 5: reset mid-frame, then a fresh frame lands in bank 1
        for (int i = 0; i < 700; i++) send_byte(8'(i * 3), 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i), i == 19, 1'b1);
        idle(1'b1, 14'd0, 2);
        check("t5_addr0", {24'd0, bus.rd_data}, 32'h40);
        check("t5_count", {24'd0, bus.frame_count}, 32'd1);

        // 6: frame_count wrap and read-start clear
        for (int i = 0; i < 255; i++) send_byte(8'(i), 1'b1, 1'b1);
        idle(1'b1, 14'd0, 1);
        check("t6_wrap", {24'd0, bus.frame_count}, 32'd0);
        check("t6_ready", {31'd0, bus.frame_ready}, 32'd1);
        idle(1'b0, 14'd0, 3);
        check("t6_ready_clr", {31'd0, bus.frame_ready}, 32'd0);

        // Randomized traffic with transfers opening and closing
        begin
            logic c;
            c = 1'b1;
            for (int n = 0; n < 4000; n++) begin
                logic [AW-1:0] a;
                if ($urandom_range(0, 39) == 0) c = ~c;
                if ($urandom_range(0, 9) == 0) a = 14'($urandom);
                else a = 14'($urandom_range(0, DEPTH + 15));
                cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 59) == 0, c, a, acc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
